// File: rtl/ci_window_ctrl.sv
// ci_window_ctrl: streams raster pixels through four line buffers into a 5x5 window and registers CI maps.
// Define CI_FRAME_STATS_EN to add o_win_count and o_err_sticky.
module ci_window_ctrl #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_pixel,
  input  logic                  i_pixel_valid,
  output logic                  o_pixel_ready,
  output logic [25*WIDTH-1:0]   o_win,
  input  logic [24:0]           i_ci_bits,
  output logic [24:0]           o_ci_map,
  output logic                  o_ci_valid,
  input  logic                  i_ci_ready,
  output logic                  o_busy,
  output logic                  o_done
`ifdef CI_FRAME_STATS_EN
  ,
  output logic [$clog2((IMG_W-4)*(IMG_H-4)+1)-1:0] o_win_count,
  output logic                  o_err_sticky
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic win_valid, out_free, acc, take, col_last, row_last;
  logic [WIDTH-1:0] lb [4][IMG_W];
  logic [WIDTH-1:0] new_col [5];
  assign out_free      = !o_ci_valid || i_ci_ready;
  assign o_pixel_ready = state == RUN && (!win_valid || out_free);
  assign acc           = i_pixel_valid && o_pixel_ready;
  assign take          = win_valid && out_free;
  assign col_last      = col == CW'(IMG_W-1);
  assign row_last      = row == RW'(IMG_H-1);
  assign o_busy        = state != IDLE;
  // lb[3] holds the oldest row, so it feeds window row 0
  always_comb begin
    new_col[0] = lb[3][col];
    new_col[1] = lb[2][col];
    new_col[2] = lb[1][col];
    new_col[3] = lb[0][col];
    new_col[4] = i_pixel;
  end
  always_ff @(posedge i_clk)
    if (acc) begin
      lb[0][col] <= i_pixel;
      for (int i = 1; i < 4; i++) lb[i][col] <= lb[i-1][col];
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_win <= '0;
    else if (acc)
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) o_win[(r*5+c)*WIDTH +: WIDTH] <= o_win[(r*5+c+1)*WIDTH +: WIDTH];
        o_win[(r*5+4)*WIDTH +: WIDTH] <= new_col[r];
      end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      o_ci_valid <= 1'b0;
      o_ci_map   <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (acc) win_valid <= row >= RW'(4) && col >= CW'(4);
      else if (take) win_valid <= 1'b0;
      if (take) begin
        o_ci_map   <= i_ci_bits;
        o_ci_valid <= 1'b1;
      end else if (i_ci_ready) o_ci_valid <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= RUN;
          col   <= '0;
          row   <= '0;
        end
        RUN: if (acc) begin
          col <= col_last ? '0 : col + 1'b1;
          if (col_last) row <= row_last ? '0 : row + 1'b1;
          if (col_last && row_last) state <= DRAIN;
        end
        DRAIN: if (!win_valid && !o_ci_valid) begin
          state  <= IDLE;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef CI_FRAME_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_win_count  <= '0;
      o_err_sticky <= 1'b0;
    end else if (state == IDLE && i_start) begin
      o_win_count  <= '0;
      o_err_sticky <= 1'b0;
    end else begin
      if (o_ci_valid && i_ci_ready) o_win_count <= o_win_count + 1'b1;
      if (state == DRAIN && i_pixel_valid) o_err_sticky <= 1'b1;
    end
`endif
endmodule
